// File: rtl/mac_acc_reader.sv
// Read side of the MAC accumulator: counts loads, captures every ACC_LEN-th value, queues results.
// Optional build macro SAT_OUT_EN: saturate results to OUT_W bits instead of truncating.
module mac_acc_reader #(
  parameter int ACC_W      = 12,
  parameter int OUT_W      = 8,
  parameter int ACC_LEN    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_acc,
  input  logic [ACC_W-1:0] tacc_in,
  output logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             ovf
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic [FC_W-1:0]  FC_FULL  = FC_W'(FIFO_DEPTH);

  typedef enum logic {ST_COUNT, ST_CAPTURE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             acc_clr_reg;
  logic             wrap;
  logic             capture;

  assign wrap    = ld_acc && (cnt_reg == CNT_LAST);
  assign capture = (state_reg == ST_CAPTURE);
  assign acc_clr = acc_clr_reg;

  // A load arriving during CAPTURE is simply counted toward the next window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_COUNT;
      cnt_reg     <= '0;
      acc_clr_reg <= 1'b0;
    end else begin
      if (ld_acc) cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
      state_reg   <= wrap ? ST_CAPTURE : ST_COUNT;
      acc_clr_reg <= wrap;
    end
  end

  logic [OUT_W-1:0] conv_val;

`ifdef SAT_OUT_EN
  if (ACC_W > OUT_W) begin : g_sat
    assign conv_val = (|tacc_in[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : tacc_in[OUT_W-1:0];
  end else begin : g_wide
    assign conv_val = OUT_W'(tacc_in);
  end
`else
  if (ACC_W > OUT_W) begin : g_trunc
    logic unused_hi;
    assign conv_val  = tacc_in[OUT_W-1:0];
    assign unused_hi = ^tacc_in[ACC_W-1:OUT_W];
  end else begin : g_wide
    assign conv_val = OUT_W'(tacc_in);
  end
`endif

  // Shift-register FIFO: entry 0 is the head and drives out_data directly.
  logic [OUT_W-1:0] mem_reg   [FIFO_DEPTH];
  logic [OUT_W-1:0] shift_val [FIFO_DEPTH];
  logic             shift_ok  [FIFO_DEPTH];
  logic [FC_W-1:0]  fifo_cnt_reg;
  logic             ovf_reg;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [FC_W-1:0]  wpos;

  assign full      = (fifo_cnt_reg == FC_FULL);
  assign out_valid = (fifo_cnt_reg != '0);
  assign pop       = out_valid && out_ready;
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign wpos      = pop ? fifo_cnt_reg - FC_W'(1) : fifo_cnt_reg;
  assign out_data  = mem_reg[0];
  assign ovf       = ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_ent
      if (gi < FIFO_DEPTH - 1) begin : g_shift
        assign shift_val[gi] = mem_reg[gi+1];
        assign shift_ok[gi]  = (FC_W'(gi + 1) < fifo_cnt_reg);
      end else begin : g_tail
        assign shift_val[gi] = '0;
        assign shift_ok[gi]  = 1'b0;
      end

      // Entries past the valid count are left alone so the head holds when the FIFO empties.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push && (wpos == FC_W'(gi))) begin
          mem_reg[gi] <= conv_val;
        end else if (pop && shift_ok[gi]) begin
          mem_reg[gi] <= shift_val[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      fifo_cnt_reg <= fifo_cnt_reg + FC_W'(push) - FC_W'(pop);
      if (drop) ovf_reg <= 1'b1;
    end
  end

endmodule
